fifo4_sync: RTL and testbench

- Four-entry, 8-bit synchronous first-in/first-out queue with show-ahead output.
- Used as a small decoupling buffer between a producer issuing write strobes and a consumer issuing read strobes, both in a single clock domain.
- Provides full/empty status and an occupancy count.

---
 rtl/fifo4_sync_if.sv | 50 +++++
 rtl/fifo4_sync.sv | 94 +++++++++
 tb/tb_fifo4_sync.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fifo4_sync_if.sv
// rtl/fifo4_sync_if.sv - producer/consumer handshake bundle for fifo4_sync
//
// Purpose: groups the write/read strobes, write data, head data and status
//          of fifo4_sync so they can be passed as a single port.
// Optional: FIFO4_SYNC_ERR_EN adds the sticky overflow/underflow flags.
// Signals:
//   write, din   producer write strobe and data
//   read         consumer read strobe
//   dout         head entry (show-ahead)
//   full, empty  status derived from count
//   count        number of valid entries
//   overflow     sticky: write refused because the queue was full (FIFO4_SYNC_ERR_EN)
//   underflow    sticky: read refused because the queue was empty (FIFO4_SYNC_ERR_EN)
// Modports: master = user side, slave = queue side.
interface fifo4_sync_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 3
);
    logic                  write;
    logic [DATA_WIDTH-1:0] din;
    logic                  read;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic [CNT_WIDTH-1:0]  count;
`ifdef FIFO4_SYNC_ERR_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write, din, read,
        input  dout, full, empty, count, overflow, underflow
    );

    modport slave (
        input  write, din, read,
        output dout, full, empty, count, overflow, underflow
    );
`else
    modport master (
        output write, din, read,
        input  dout, full, empty, count
    );

    modport slave (
        input  write, din, read,
        output dout, full, empty, count
    );
`endif
endinterface

// File: rtl/fifo4_sync.sv
// rtl/fifo4_sync.sv - four-entry synchronous show-ahead FIFO
//
// Purpose: small single-clock decoupling queue between a producer issuing
//          write strobes and a consumer issuing read strobes.
// Optional: FIFO4_SYNC_ERR_EN adds sticky overflow/underflow outputs on bus.
// Ports:
//   clk   clock, all state updates on the rising edge
//   clrn  synchronous active-low reset (clears pointers, count and storage)
//   bus   fifo4_sync_if.slave: write/din/read in, dout/full/empty/count out
module fifo4_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic          clk,
    input  logic          clrn,
    fifo4_sync_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wp;
    logic [PTR_W-1:0]      rp;
    logic [CNT_WIDTH-1:0]  cnt;

    logic full_w;
    logic empty_w;
    logic wr_ok;
    logic rd_ok;

    assign full_w  = (cnt == CNT_WIDTH'(DEPTH));
    assign empty_w = (cnt == '0);

    // A concurrent read frees the head slot, so a full queue still accepts
    // the write. A read on an empty queue is never accepted, even when a
    // write lands in the same cycle (no bypass path).
    assign wr_ok = bus.write & (~full_w | bus.read);
    assign rd_ok = bus.read & ~empty_w;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wp] <= bus.din;
                wp      <= wp + PTR_W'(1);
            end
            if (rd_ok) begin
                rp <= rp + PTR_W'(1);
            end
            if (wr_ok && !rd_ok) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end else if (rd_ok && !wr_ok) begin
                cnt <= cnt - CNT_WIDTH'(1);
            end
        end
    end

    // Show-ahead: the head word is visible without a read strobe.
    assign bus.dout  = mem[rp];
    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.count = cnt;

`ifdef FIFO4_SYNC_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Sticky until reset; raised on the refused operation only.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.write && full_w && !bus.read) begin
                ovf_q <= 1'b1;
            end
            if (bus.read && empty_w) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo4_sync.sv
// tb/tb_fifo4_sync.sv - directed self-checking bench for fifo4_sync
module tb_fifo4_sync;

    logic clk;
    logic clrn;
    int   checks;
    int   errors;

    fifo4_sync_if #(.DATA_WIDTH(8), .CNT_WIDTH(3)) bus ();

    fifo4_sync #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(3)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] e_vec [4];
    logic [7:0] b_vec [6];
    logic [7:0] wrap_exp [6];

    initial begin
        checks = 0;
        errors = 0;
        e_vec    = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        b_vec    = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        wrap_exp = '{8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hB3};

        // Reset has priority over a held write strobe.
        clrn      = 1'b0;
        bus.write = 1'b1;
        bus.din   = 8'hFF;
        bus.read  = 1'b0;
        step();
        step();
        clrn      = 1'b1;
        bus.write = 1'b0;
        step();
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full",  32'(bus.full),  32'd0);
        check_eq("rst_dout",  32'(bus.dout),  32'h00);
`ifdef FIFO4_SYNC_ERR_EN
        check_eq("rst_ovf", 32'(bus.overflow),  32'd0);
        check_eq("rst_unf", 32'(bus.underflow), 32'd0);
`endif

        // Fill with back-to-back writes.
        bus.write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.din = e_vec[i];
            step();
            check_eq("fill_count", 32'(bus.count), 32'(i + 1));
            check_eq("fill_dout",  32'(bus.dout),  32'hE1);
            check_eq("fill_empty", 32'(bus.empty), 32'd0);
            check_eq("fill_full",  32'(bus.full),  (i == 3) ? 32'd1 : 32'd0);
        end
        bus.write = 1'b0;

        // Write while full is dropped.
        bus.write = 1'b1;
        bus.din   = 8'h55;
        step();
        bus.write = 1'b0;
        check_eq("ovf_count", 32'(bus.count), 32'd4);
        check_eq("ovf_full",  32'(bus.full),  32'd1);
        check_eq("ovf_dout",  32'(bus.dout),  32'hE1);
`ifdef FIFO4_SYNC_ERR_EN
        check_eq("ovf_flag", 32'(bus.overflow), 32'd1);
`endif

        // Drain: head shows each word before its pop.
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_dout", 32'(bus.dout), 32'(e_vec[i]));
            bus.read = 1'b1;
            step();
            bus.read = 1'b0;
            check_eq("drain_count", 32'(bus.count), 32'(3 - i));
        end
        check_eq("drain_empty", 32'(bus.empty), 32'd1);

        // Read on empty changes nothing.
        bus.read = 1'b1;
        step();
        bus.read = 1'b0;
        check_eq("unf_count", 32'(bus.count), 32'd0);
        check_eq("unf_empty", 32'(bus.empty), 32'd1);
`ifdef FIFO4_SYNC_ERR_EN
        check_eq("unf_flag", 32'(bus.underflow), 32'd1);
`endif

        // Wrap: A0..A2, pop once, then six simultaneous read+write.
        bus.write = 1'b1;
        bus.din = 8'hA0; step();
        bus.din = 8'hA1; step();
        bus.din = 8'hA2; step();
        bus.write = 1'b0;
        bus.read  = 1'b1;
        step();
        bus.read  = 1'b0;
        check_eq("wrap_pre_count", 32'(bus.count), 32'd2);
        bus.write = 1'b1;
        bus.read  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.din = b_vec[i];
            check_eq("wrap_dout", 32'(bus.dout), 32'(wrap_exp[i]));
            step();
            check_eq("wrap_count", 32'(bus.count), 32'd2);
        end
        bus.write = 1'b0;
        check_eq("wrap_tail0", 32'(bus.dout), 32'hB4);
        step();
        bus.read = 1'b0;
        check_eq("wrap_tail1", 32'(bus.dout), 32'hB5);
        bus.read = 1'b1;
        step();
        check_eq("wrap_empty", 32'(bus.empty), 32'd1);

        // Read+write on empty: write only, no bypass.
        bus.write = 1'b1;
        bus.din   = 8'hC3;
        step();
        bus.write = 1'b0;
        bus.read  = 1'b0;
        check_eq("rw_empty_count", 32'(bus.count), 32'd1);
        check_eq("rw_empty_dout",  32'(bus.dout),  32'hC3);

        // Read+write while full: both accepted.
        bus.write = 1'b1;
        bus.din = 8'hD1; step();
        bus.din = 8'hD2; step();
        bus.din = 8'hD3; step();
        check_eq("rwf_pre_full", 32'(bus.full), 32'd1);
        bus.read = 1'b1;
        bus.din  = 8'hD4;
        step();
        bus.write = 1'b0;
        bus.read  = 1'b0;
        check_eq("rwf_count", 32'(bus.count), 32'd4);
        check_eq("rwf_full",  32'(bus.full),  32'd1);
        check_eq("rwf_dout",  32'(bus.dout),  32'hD1);

        // Reset mid-operation discards contents and sticky flags.
        clrn = 1'b0;
        step();
        clrn = 1'b1;
        check_eq("mid_rst_empty", 32'(bus.empty), 32'd1);
        check_eq("mid_rst_count", 32'(bus.count), 32'd0);
        check_eq("mid_rst_dout",  32'(bus.dout),  32'h00);
`ifdef FIFO4_SYNC_ERR_EN
        check_eq("mid_rst_ovf", 32'(bus.overflow),  32'd0);
        check_eq("mid_rst_unf", 32'(bus.underflow), 32'd0);
`endif
        bus.write = 1'b1;
        bus.din   = 8'h77;
        step();
        bus.write = 1'b0;
        check_eq("post_rst_dout",  32'(bus.dout),  32'h77);
        check_eq("post_rst_count", 32'(bus.count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
